// File: rtl/fft_shift_ctrl.sv
// Purpose: ping-pong write/read controller for the FFT reorder RAM. It writes each frame half-swapped and reads it out in fftshift order.
// Latency: 4 cycles from the last accepted input sample to the first o_DV. After that, output runs at 1 sample/cycle.
// Backpressure: none. Input may arrive at up to 1 sample/cycle, and the reader always keeps pace with the writer.
module fft_shift_ctrl #(
    parameter int WIDTH = 16,
    parameter int N     = 64,
    localparam int AW   = $clog2(2*N),
    localparam int IW   = $clog2(N)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_DV,
    input  logic [WIDTH-1:0] i_Data,
    input  logic             i_SOF,
    output logic [AW-1:0]    o_Wr_Addr,
    output logic             o_Wr_DV,
    output logic [WIDTH-1:0] o_Wr_Data,
    output logic [AW-1:0]    o_Rd_Addr,
    output logic             o_Rd_En,
    input  logic             i_Rd_DV,
    input  logic [WIDTH-1:0] i_Rd_Data,
    output logic             o_DV,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_SOF,
    output logic             o_Frame_Err
);

    typedef enum logic {IDLE, READ} rd_state_t;

    // XOR with the top index bit swaps the two halves of the frame.
    localparam logic [IW-1:0] HALF = {1'b1, {(IW-1){1'b0}}};
    localparam logic [IW-1:0] ONE  = {{(IW-1){1'b0}}, 1'b1};

    rd_state_t     state, state_nxt;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx, rd_idx_nxt;
    logic          wr_bank;
    logic          rd_bank, rd_bank_nxt;
    logic [1:0]    full, full_set, full_clr;
    logic          resync;
    logic [IW-1:0] wr_slot;
    logic          rd_sof_p1, rd_sof_p2;

    // An SOF that arrives mid-frame abandons the partial frame.
    // That SOF sample restarts the same bank at index 0.
    assign resync  = i_DV & i_SOF & (wr_idx != '0);
    assign wr_slot = resync ? '0 : wr_idx;

    // Flag a bank as full when its last sample is accepted.
    always_comb begin
        full_set = 2'b00;
        if (i_DV && !resync && (&wr_idx))
            full_set[wr_bank] = 1'b1;
    end

    // Write port: register each accepted sample at its half-swapped address.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Wr_DV     <= 1'b0;
            o_Wr_Data   <= '0;
            o_Wr_Addr   <= '0;
            o_Frame_Err <= 1'b0;
            wr_idx      <= '0;
            wr_bank     <= 1'b0;
        end else if (i_DV) begin
            o_Wr_DV     <= 1'b1;
            o_Wr_Data   <= i_Data;
            o_Wr_Addr   <= {wr_bank, wr_slot ^ HALF};
            o_Frame_Err <= resync;
            if (resync) begin
                wr_idx <= ONE;
            end else if (&wr_idx) begin
                wr_idx  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_idx <= wr_idx + ONE;
            end
        end else begin
            o_Wr_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
        end
    end

    // Reader next state: claim a full bank, sweep it, and chain into the other bank without a gap if it is ready.
    always_comb begin
        state_nxt   = state;
        rd_idx_nxt  = rd_idx;
        rd_bank_nxt = rd_bank;
        full_clr    = 2'b00;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt         = READ;
                    rd_idx_nxt        = '0;
                    full_clr[rd_bank] = 1'b1;
                end
            end
            READ: begin
                if (&rd_idx) begin
                    rd_bank_nxt = ~rd_bank;
                    rd_idx_nxt  = '0;
                    if (full[~rd_bank])
                        full_clr[~rd_bank] = 1'b1;
                    else
                        state_nxt = IDLE;
                end else begin
                    rd_idx_nxt = rd_idx + ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reader state, full flags (a set beats a clear) and registered read port.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= IDLE;
            rd_idx    <= '0;
            rd_bank   <= 1'b0;
            full      <= 2'b00;
            o_Rd_En   <= 1'b0;
            o_Rd_Addr <= '0;
            rd_sof_p1 <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_idx    <= rd_idx_nxt;
            rd_bank   <= rd_bank_nxt;
            full      <= (full & ~full_clr) | full_set;
            o_Rd_En   <= (state == READ);
            rd_sof_p1 <= (state == READ) && (rd_idx == '0);
            if (state == READ)
                o_Rd_Addr <= {rd_bank, rd_idx};
        end
    end

    // Output stage: register the RAM data and carry the frame-start mark alongside it.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rd_sof_p2 <= 1'b0;
            o_DV      <= 1'b0;
            o_Data    <= '0;
            o_SOF     <= 1'b0;
        end else begin
            rd_sof_p2 <= rd_sof_p1;
            o_DV      <= i_Rd_DV;
            o_Data    <= i_Rd_Data;
            o_SOF     <= rd_sof_p2;
        end
    end

endmodule
